// File: rtl/compute_sequencer.sv
// Phase sequencer for the matrix-multiply datapath: run-edge start, done handshakes, display rotation.
// Optional per-phase watchdog and ERROR state enabled by defining COMPUTE_SEQUENCER_WATCHDOG_EN.
module compute_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DISP_HOLD      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       done_capture,
  input  logic       done_send,
  input  logic       done_PE,
  input  logic       done_SA_3x3,
  input  logic       done_SA_2x2,
  output logic       state_idle,
  output logic       state_capture,
  output logic       state_send,
  output logic       state_PE,
  output logic       state_SA_3x3,
  output logic       state_SA_2x2,
  output logic       state_display,
  output logic [2:0] current_state,
  output logic       busy,
  output logic [1:0] disp_sel,
  output logic [1:0] disp_elem,
  output logic       frame_done,
  output logic       stage_timeout,
  output logic [2:0] error_stage
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SEND    = 3'd2,
    S_PE      = 3'd3,
    S_SA3     = 3'd4,
    S_SA2     = 3'd5,
    S_DISPLAY = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  localparam int HOLD_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DISP_HOLD - 1);

  state_e            state_q, state_d;
  logic              run_q;
  logic              run_edge;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        elem_q, elem_d;
  logic              stage_done;
  logic              in_handshake;
  logic              timeout_hit;

  assign run_edge     = run & ~run_q;
  assign in_handshake = (state_q == S_CAPTURE) || (state_q == S_SEND) || (state_q == S_PE) ||
                        (state_q == S_SA3) || (state_q == S_SA2);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    sel_d      = sel_q;
    elem_d     = elem_q;
    frame_done = 1'b0;
    stage_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_edge) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        stage_done = done_capture;
        if (done_capture) state_d = S_SEND;
      end
      S_SEND: begin
        stage_done = done_send;
        if (done_send) state_d = S_PE;
      end
      S_PE: begin
        stage_done = done_PE;
        if (done_PE) state_d = S_SA3;
      end
      S_SA3: begin
        stage_done = done_SA_3x3;
        if (done_SA_3x3) state_d = S_SA2;
      end
      S_SA2: begin
        stage_done = done_SA_2x2;
        if (done_SA_2x2) state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        // Element advances when its hold wraps; result set advances when the element wraps.
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (elem_q == 2'd3) begin
            elem_d = 2'd0;
            if (sel_q == 2'd2) begin
              sel_d      = 2'd0;
              frame_done = 1'b1;
              state_d    = S_IDLE;
            end else begin
              sel_d = sel_q + 2'd1;
            end
          end else begin
            elem_d = elem_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_ERROR: begin
        if (run_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A done arriving on the last watchdog cycle wins over the timeout.
    if (timeout_hit) state_d = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      hold_q  <= '0;
      sel_q   <= 2'd0;
      elem_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      elem_q  <= elem_d;
    end
  end

`ifdef COMPUTE_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            stage_timeout_q;
  logic [2:0]      error_stage_q;

  assign timeout_hit = in_handshake && !stage_done && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q        <= '0;
      stage_timeout_q <= 1'b0;
      error_stage_q   <= 3'd0;
    end else begin
      if (state_d != state_q) wd_cnt_q <= '0;
      else if (in_handshake)  wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (timeout_hit) begin
        stage_timeout_q <= 1'b1;
        error_stage_q   <= state_q;
      end else if (state_q == S_ERROR && run_edge) begin
        stage_timeout_q <= 1'b0;
        error_stage_q   <= 3'd0;
      end
    end
  end

  assign stage_timeout = stage_timeout_q;
  assign error_stage   = error_stage_q;
`else
  logic unused_wd;
  assign unused_wd     = |{TIMEOUT_CYCLES, stage_done, in_handshake};
  assign timeout_hit   = 1'b0;
  assign stage_timeout = 1'b0;
  assign error_stage   = 3'd0;
`endif

  assign current_state = state_q;
  assign state_idle    = (state_q == S_IDLE);
  assign state_capture = (state_q == S_CAPTURE);
  assign state_send    = (state_q == S_SEND);
  assign state_PE      = (state_q == S_PE);
  assign state_SA_3x3  = (state_q == S_SA3);
  assign state_SA_2x2  = (state_q == S_SA2);
  assign state_display = (state_q == S_DISPLAY);
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign disp_sel      = sel_q;
  assign disp_elem     = elem_q;

endmodule

// File: doc/compute_sequencer.md
# compute_sequencer

Top-level sequencer for the matrix-multiply datapath. Walks the capture, send, single-PE, 3x3 systolic, 2x2 systolic and display phases, handshaking with each engine's `done_*` pulse, and guards each compute phase with a watchdog. It also drives the display rotation, stepping through result set and element so the display path only needs a mux. It sits between the external `run` button and the memory, core and display blocks, and drives their one-hot `state_*` enables.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum cycles allowed in any handshake state before timeout (≥2).
- `DISP_HOLD`, default 4: cycles each displayed element is held (≥1).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset (single clock domain).
- `run`  in  1  start request, level; its rising edge is used.
- `done_capture`, `done_send`, `done_PE`, `done_SA_3x3`, `done_SA_2x2`  in  1 each  engine completion pulses.
- `state_idle`, `state_capture`, `state_send`, `state_PE`, `state_SA_3x3`, `state_SA_2x2`, `state_display`  out  1 each  one-hot phase enables.
- `current_state`  out  3  encoded state.
- `busy`  out  1  high in states 1..6.
- `disp_sel`  out  2  result set shown: 0 = PE, 1 = 3x3, 2 = 2x2.
- `disp_elem`  out  2  element shown: 0 = c11, 1 = c12, 2 = c21, 3 = c22.
- `frame_done`  out  1  one-cycle pulse at end of display.
- `stage_timeout`  out  1  sticky watchdog error flag.
- `error_stage`  out  3  state code that timed out.

## Operation
- **State codes:** IDLE=0, CAPTURE=1, SEND=2, PE=3, SA3=4, SA2=5, DISPLAY=6, ERROR=7.
- **State outputs:** `state_*` and `current_state` decode the state register directly (Moore). ERROR asserts no `state_*` line.
- **Run edge:** `run_q` is a register; `run_edge = run & ~run_q`.
- **IDLE:** on `run_edge`, go to CAPTURE.
- **Handshake states 1..5:** advance to the next state in order when the matching `done_*` is high.
  - Non-matching `done_*` pulses are ignored.
  - SA2 advances to DISPLAY.
- **Watchdog:**
  - Counter clears on entry to each handshake state.
  - If the counter equals `TIMEOUT_CYCLES-1` and the matching done is low, go to ERROR.
  - On that transition, set `stage_timeout` and latch the current code into `error_stage`.
  - If done and the timeout coincide in the same cycle, done wins.
- **DISPLAY:**
  - A hold counter counts 0..`DISP_HOLD-1`; `disp_elem` increments on wrap.
  - When `disp_elem` wraps 3→0, `disp_sel` increments.
  - After sel=2, elem=3 completes its hold: pulse `frame_done`, go to IDLE, and reset `disp_sel`/`disp_elem` to 0.
- **ERROR:** hold until `run_edge`, then go to IDLE and clear `stage_timeout` and `error_stage`.
- **`run_edge` in states 1..6:** ignored; no restart.
- **Reset mid-operation:** next cycle is IDLE with all outputs at reset values, regardless of pending done pulses.

## Timing
- **Reset values:**
  - `state_idle`=1; all other `state_*`=0.
  - `current_state`=0, `busy`=0, `disp_sel`=0, `disp_elem`=0.
  - `frame_done`=0, `stage_timeout`=0, `error_stage`=0, `run_q`=0.
- **Edge latency:** `run` rising in cycle t (sampled at the edge ending t) makes `state_capture` high in cycle t+1.
- **Done latency:** `done_*` high in cycle t while in the matching state moves the next state into cycle t+1. Engines see their enable drop one cycle after done.
- **Minimum handshake time:** if every done is already high on entry, each of states 1..5 lasts exactly one cycle.
- **Timeout latency:** entry at cycle e with no done gives ERROR in cycle e+`TIMEOUT_CYCLES`.
- **Display length:** exactly 12·`DISP_HOLD` cycles.
  - `frame_done` is high in the last DISPLAY cycle.
  - `state_idle` is high the following cycle.
- **Display outputs:** `disp_sel`/`disp_elem` are registered; they change on the cycle boundary after the hold wrap.

## Configuration
- Macro `COMPUTE_SEQUENCER_WATCHDOG_EN`.
- **Defined:** watchdog counter, ERROR state, `stage_timeout` and `error_stage` are implemented as described.
- **Undefined:**
  - No watchdog counter; handshake states wait indefinitely.
  - ERROR is unreachable.
  - `stage_timeout` and `error_stage` are tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- **Reset:** assert reset 3 cycles, release → `current_state`=0, `state_idle`=1, `busy`=0, `stage_timeout`=0.
- **Full pass:** `run` edge, each done pulsed 2 cycles after state entry, `DISP_HOLD`=4.
  - Visits states 1→2→3→4→5→6, each handshake state 3 cycles.
  - DISPLAY spans 48 cycles, `disp_sel`/`disp_elem` sequence 0/0..2/3.
  - `frame_done` pulses once, then IDLE.
- **Timeout:** hold `done_SA_3x3` low, `TIMEOUT_CYCLES`=16.
  - ERROR is reached 16 cycles after SA3 entry; `error_stage`=4, `stage_timeout`=1.
  - Next `run` edge → IDLE with flags cleared.
- **Stray events:** pulse `done_SA_2x2` during PE and toggle `run` during SEND → no state change; PE still waits for `done_PE`.
- **Simultaneous:** `done_send` high exactly at count `TIMEOUT_CYCLES-1` → goes to PE, not ERROR.
- **Reset mid-run:** reset asserted during DISPLAY at sel=1, elem=2 → next cycle IDLE, `disp_sel`=0, `disp_elem`=0, `frame_done`=0.
